// File: rtl/irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_request_latch
// Description : Interrupt front end. Each of the 8 async request lines goes
//               through an input capture flop and a SYNC_STAGES-deep
//               synchroniser. Rising edges are latched into raw_pending and
//               masked by a per-line enable. The masked vector and a valid
//               strobe go to the priority encoder. A claim handshake
//               (ack + id, then eoi) runs with the consumer.
//               Optional feature: define IRQ_LEVEL_MODE_EN for level-sensitive
//               requests (raw_pending follows the synchronised lines, and ack
//               does not clear them).
// Revision    : 1.0 - initial release
// ============================================================================
module irq_request_latch #(
  parameter int         SYNC_STAGES = 2,      // legal 2..4
  parameter logic [7:0] EN_RESET    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       en_wr,
  input  logic [7:0] en_wdata,
  output logic [7:0] irq_en,
  output logic [7:0] pending,
  output logic       irq_valid,
  input  logic       ack,
  input  logic [2:0] ack_id,
  input  logic       eoi,
  output logic       in_service,
  output logic [2:0] service_id
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]                  state;
  logic [1:0]                  state_nxt;
  logic [SYNC_STAGES:0][7:0]   sync_chain;
  logic [7:0]                  sync_out;
  logic [7:0]                  raw_pending;
  logic                        claim;

  // Element 0 is the capture flop; the last element is the synchronised line.
  assign sync_out = sync_chain[SYNC_STAGES];

  // A claim is only honoured while the request is being presented.
  assign claim = (state == ST_ASSERT) && ack;

  // Capture and synchronise the request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-1:0], irq_in};
    end
  end

`ifdef IRQ_LEVEL_MODE_EN
  // Level mode: pending mirrors the synchronised lines; the source must deassert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_pending <= '0;
    end else begin
      raw_pending <= sync_out;
    end
  end
`else
  logic [7:0] hist;
  logic [7:0] rise;
  logic [7:0] clr_mask;

  // History starts at 0, so a line already high at reset release is an edge.
  assign rise     = sync_out & ~hist;
  assign clr_mask = claim ? (8'h01 << ack_id) : 8'h00;

  // Remember last synchronised value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else begin
      hist <= sync_out;
    end
  end

  // Latch rising edges; a new edge on a bit being claimed keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_pending <= '0;
    end else begin
      raw_pending <= (raw_pending & ~clr_mask) | rise;
    end
  end
`endif

  // Enable register; disabled lines keep latching underneath the mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= EN_RESET;
    end else if (en_wr) begin
      irq_en <= en_wdata;
    end
  end

  assign pending = raw_pending & irq_en;

  // Capture the claimed id; it holds until the next claim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      service_id <= '0;
    end else if (claim) begin
      service_id <= ack_id;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: ack outranks both eoi and a withdrawn request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pending != 8'h00) state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (ack)                    state_nxt = ST_SERVICE;
        else if (pending == 8'h00)  state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eoi) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state; no nesting while in service.
  always_comb begin
    irq_valid  = 1'b0;
    in_service = 1'b0;
    case (state)
      ST_ASSERT:  irq_valid  = 1'b1;
      ST_SERVICE: in_service = 1'b1;
      default: begin
        irq_valid  = 1'b0;
        in_service = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_request_latch
// Description : Self-checking bench for irq_request_latch (default edge mode).
//               A behavioural model tracks the request path as "input sample
//               from N edges ago" and the claim handshake; it is compared
//               against the DUT every falling edge. Directed literal checks
//               pin the model at the key points of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_request_latch;

  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;  // edges from sample to raw_pending
  localparam int M_IDLE      = 0;
  localparam int M_ASSERT    = 1;
  localparam int M_SERVICE   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       en_wr;
  logic [7:0] en_wdata;
  logic [7:0] irq_en;
  logic [7:0] pending;
  logic       irq_valid;
  logic       ack;
  logic [2:0] ack_id;
  logic       eoi;
  logic       in_service;
  logic [2:0] service_id;

  int checks = 0;
  int errors = 0;

  irq_request_latch #(.SYNC_STAGES(SYNC_STAGES), .EN_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .en_wr(en_wr), .en_wdata(en_wdata),
    .irq_en(irq_en), .pending(pending), .irq_valid(irq_valid), .ack(ack),
    .ack_id(ack_id), .eoi(eoi), .in_service(in_service), .service_id(service_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_smp[k] is the irq_in value sampled k edges ago.
  logic [7:0] m_smp [1:SYNC_STAGES+2];
  logic [7:0] m_raw;
  logic [7:0] m_en;
  logic [2:0] m_sid;
  int         m_st;

  function automatic logic [7:0] f_raw(input logic [7:0] raw, input logic [7:0] seen,
                                       input logic [7:0] prev, input int st,
                                       input logic ak, input logic [2:0] id);
    logic [7:0] clr;
    clr = (st == M_ASSERT && ak) ? (8'h01 << id) : 8'h00;
    return (raw & ~clr) | (seen & ~prev);
  endfunction

  function automatic int f_st(input int st, input logic [7:0] pend, input logic ak, input logic ek);
    if (st == M_IDLE)   return (pend != 8'h00) ? M_ASSERT : M_IDLE;
    if (st == M_ASSERT) return ak ? M_SERVICE : ((pend == 8'h00) ? M_IDLE : M_ASSERT);
    return ek ? M_IDLE : M_SERVICE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= SYNC_STAGES + 2; k++) m_smp[k] <= 8'h00;
      m_raw <= 8'h00;
      m_en  <= 8'h00;
      m_sid <= 3'd0;
      m_st  <= M_IDLE;
    end else begin
      m_raw <= f_raw(m_raw, m_smp[LAT], m_smp[LAT+1], m_st, ack, ack_id);
      m_st  <= f_st(m_st, m_raw & m_en, ack, eoi);
      if (m_st == M_ASSERT && ack) m_sid <= ack_id;
      if (en_wr) m_en <= en_wdata;
      m_smp[1] <= irq_in;
      for (int k = 2; k <= SYNC_STAGES + 2; k++) m_smp[k] <= m_smp[k-1];
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_irq_en", irq_en, m_en);
    chk("cyc_pending", pending, m_raw & m_en);
    chk("cyc_irq_valid", {7'b0, irq_valid}, {7'b0, (m_st == M_ASSERT)});
    chk("cyc_in_service", {7'b0, in_service}, {7'b0, (m_st == M_SERVICE)});
    chk("cyc_service_id", {5'b0, service_id}, {5'b0, m_sid});
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack(input logic [2:0] id);
    ack = 1'b1; ack_id = id; tick(1); ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1; tick(1); eoi = 1'b0;
  endtask

  task automatic wr_en(input logic [7:0] v);
    en_wr = 1'b1; en_wdata = v; tick(1); en_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; irq_in = 8'h00; en_wr = 1'b0; en_wdata = 8'h00;
    ack = 1'b0; ack_id = 3'd0; eoi = 1'b0;
    tick(2);
    chk("rst_irq_en", irq_en, 8'h00);
    chk("rst_pending", pending, 8'h00);
    chk("rst_valid", {7'b0, irq_valid}, 8'h00);
    chk("rst_in_service", {7'b0, in_service}, 8'h00);
    chk("rst_service_id", {5'b0, service_id}, 8'h00);
    rst_n = 1'b1;
    tick(1);

    // 1: single request, latency, claim, eoi
    wr_en(8'hFF);
    chk("t1_irq_en", irq_en, 8'hFF);
    irq_in = 8'h20;
    tick(3);
    chk("t1_pending_e2", pending, 8'h00);
    tick(1);
    chk("t1_pending_e3", pending, 8'h20);
    chk("t1_valid_e3", {7'b0, irq_valid}, 8'h00);
    tick(1);
    chk("t1_valid_e4", {7'b0, irq_valid}, 8'h01);
    do_ack(3'd5);
    chk("t1_ack_pending", pending, 8'h00);
    chk("t1_ack_in_service", {7'b0, in_service}, 8'h01);
    chk("t1_ack_sid", {5'b0, service_id}, 8'h05);
    chk("t1_ack_valid", {7'b0, irq_valid}, 8'h00);
    do_eoi();
    chk("t1_eoi_in_service", {7'b0, in_service}, 8'h00);
    tick(1);
    chk("t1_eoi_valid", {7'b0, irq_valid}, 8'h00);

    // 2: two simultaneous requests, back-to-back service
    irq_in = 8'h81;
    tick(4);
    chk("t2_pending", pending, 8'h81);
    tick(1);
    chk("t2_valid", {7'b0, irq_valid}, 8'h01);
    do_ack(3'd7);
    chk("t2_ack7_pending", pending, 8'h01);
    chk("t2_ack7_sid", {5'b0, service_id}, 8'h07);
    do_eoi();
    chk("t2_eoi_valid", {7'b0, irq_valid}, 8'h00);
    tick(1);
    chk("t2_reassert_valid", {7'b0, irq_valid}, 8'h01);
    do_ack(3'd0);
    chk("t2_ack0_pending", pending, 8'h00);
    chk("t2_ack0_sid", {5'b0, service_id}, 8'h00);
    do_eoi();

    // 3: masked line latches and appears when enabled
    irq_in = 8'h00;
    wr_en(8'h00);
    irq_in = 8'h08;
    tick(1);
    irq_in = 8'h00;
    tick(6);
    chk("t3_masked_pending", pending, 8'h00);
    chk("t3_masked_valid", {7'b0, irq_valid}, 8'h00);
    wr_en(8'h08);
    chk("t3_en_pending", pending, 8'h08);
    chk("t3_en_valid0", {7'b0, irq_valid}, 8'h00);
    tick(1);
    chk("t3_en_valid1", {7'b0, irq_valid}, 8'h01);
    do_ack(3'd3);
    do_eoi();

    // 4: request withdrawn by disable while asserted
    wr_en(8'hFF);
    irq_in = 8'h04;
    tick(1);
    irq_in = 8'h00;
    tick(3);
    chk("t4_pending", pending, 8'h04);
    tick(1);
    chk("t4_valid", {7'b0, irq_valid}, 8'h01);
    wr_en(8'h00);
    chk("t4_dis_pending", pending, 8'h00);
    tick(1);
    chk("t4_dis_valid", {7'b0, irq_valid}, 8'h00);
    chk("t4_dis_in_service", {7'b0, in_service}, 8'h00);

    // 5: ack+eoi together, ignored ack/eoi, non-pending id, set-wins
    wr_en(8'hFF);
    chk("t5_pending", pending, 8'h04);
    tick(1);
    ack = 1'b1; eoi = 1'b1; ack_id = 3'd2;
    tick(1);
    ack = 1'b0; eoi = 1'b0;
    chk("t5_both_in_service", {7'b0, in_service}, 8'h01);
    chk("t5_both_pending", pending, 8'h00);
    do_eoi();
    irq_in = 8'h02;
    tick(1);
    irq_in = 8'h00;
    tick(3);
    do_ack(3'd1);                        // ack while still IDLE
    chk("t5_idle_ack_pending", pending, 8'h02);
    chk("t5_idle_ack_in_service", {7'b0, in_service}, 8'h00);
    chk("t5_idle_ack_valid", {7'b0, irq_valid}, 8'h01);
    do_eoi();                            // eoi while ASSERT
    chk("t5_assert_eoi_valid", {7'b0, irq_valid}, 8'h01);
    chk("t5_assert_eoi_pending", pending, 8'h02);
    do_ack(3'd6);                        // id not pending
    chk("t5_np_in_service", {7'b0, in_service}, 8'h01);
    chk("t5_np_pending", pending, 8'h02);
    chk("t5_np_sid", {5'b0, service_id}, 8'h06);
    do_eoi();
    tick(1);
    chk("t5_b2b_valid", {7'b0, irq_valid}, 8'h01);
    do_ack(3'd1);
    do_eoi();
    irq_in = 8'h10; tick(1);
    irq_in = 8'h00; tick(1);
    irq_in = 8'h10; tick(1);
    irq_in = 8'h00; tick(2);
    do_ack(3'd4);                        // second edge lands with the clear
    chk("t5_setwins_pending", pending, 8'h10);
    chk("t5_setwins_in_service", {7'b0, in_service}, 8'h01);
    do_eoi();
    tick(1);
    do_ack(3'd4);
    do_eoi();

    // 6: async reset in SERVICE
    irq_in = 8'h30;
    tick(5);
    do_ack(3'd0);
    chk("t6_pre_pending", pending, 8'h30);
    chk("t6_pre_in_service", {7'b0, in_service}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_service", {7'b0, in_service}, 8'h00);
    chk("t6_rst_pending", pending, 8'h00);
    chk("t6_rst_irq_en", irq_en, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t6_post_valid", {7'b0, irq_valid}, 8'h00);
    wr_en(8'hFF);
    chk("t6_post_pending", pending, 8'h30);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
